// File: rtl/decode_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU op encodings and the control bundle.
// Used by decode_stage and decode_stage_regfile (REGFILE_BYPASS_EN selects write-through reads there).
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    alu_op_e alu_op;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
  } id_ctrl_t;

  localparam id_ctrl_t CTRL_NONE = '0;

  // The all-zero word is a nop even though its opcode field matches R-type.
  function automatic id_ctrl_t decode_ctrl(input logic [31:0] instr);
    id_ctrl_t c;
    c = CTRL_NONE;
    if (instr != 32'd0) begin
      case (instr[31:26])
        OP_RTYPE: begin
          c.reg_dst   = 1'b1;
          c.reg_write = 1'b1;
          c.alu_op    = ALU_OP_FUNCT;
        end
        OP_LW: begin
          c.alu_src    = 1'b1;
          c.mem_read   = 1'b1;
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
          c.alu_op     = ALU_OP_ADD;
        end
        OP_SW: begin
          c.alu_src   = 1'b1;
          c.mem_write = 1'b1;
          c.alu_op    = ALU_OP_ADD;
        end
        OP_BEQ: begin
          c.branch = 1'b1;
          c.alu_op = ALU_OP_SUB;
        end
        OP_ADDI: begin
          c.alu_src   = 1'b1;
          c.reg_write = 1'b1;
          c.alu_op    = ALU_OP_ADD;
        end
        default: c = CTRL_NONE;
      endcase
    end
    return c;
  endfunction

  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Two-read/one-write register file with r0 hardwired to zero and asynchronous clear.
// Define REGFILE_BYPASS_EN to forward a same-cycle WB write to the read ports.
module decode_stage_regfile
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs [NREGS];
  logic [1:0][REG_AW-1:0] raddr;
  logic [1:0][XLEN-1:0]   rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign raddr  = {raddr2, raddr1};
  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
`ifdef REGFILE_BYPASS_EN
      // raddr != 0 already excludes forwarding a dropped r0 write.
      assign rdata[gi] = (raddr[gi] == '0)                  ? '0    :
                         (we && (waddr == raddr[gi]))       ? wdata :
                                                              regs[raddr[gi]];
`else
      assign rdata[gi] = (raddr[gi] == '0) ? '0 : regs[raddr[gi]];
`endif
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// ID stage: control decode, register read, immediate extension, load-use hazard detection and ID/EX latch.
// REGFILE_BYPASS_EN (in decode_stage_regfile) turns on write-through register reads.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_id_instr,
  input  logic [XLEN-1:0]   if_id_npc,
  input  logic              ex_mem_pc_src,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [XLEN-1:0]   wb_write_data,
  output logic              id_stall,
  output logic              id_ex_valid,
  output logic [XLEN-1:0]   id_ex_npc,
  output logic [XLEN-1:0]   id_ex_rdata1,
  output logic [XLEN-1:0]   id_ex_rdata2,
  output logic [XLEN-1:0]   id_ex_imm,
  output logic [REG_AW-1:0] id_ex_rs,
  output logic [REG_AW-1:0] id_ex_rt,
  output logic [REG_AW-1:0] id_ex_rd,
  output logic              id_ex_reg_dst,
  output logic              id_ex_alu_src,
  output logic              id_ex_mem_read,
  output logic              id_ex_mem_write,
  output logic              id_ex_reg_write,
  output logic              id_ex_mem_to_reg,
  output logic              id_ex_branch,
  output logic [1:0]        id_ex_alu_op
);

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rdata1;
  logic [XLEN-1:0]   rdata2;
  id_ctrl_t          ctrl;
  id_ctrl_t          id_ex_ctrl;
  logic              hazard;
  logic              bubble;

  assign rs   = if_id_instr[21 +: REG_AW];
  assign rt   = if_id_instr[16 +: REG_AW];
  assign rd   = if_id_instr[11 +: REG_AW];
  assign imm  = {{(XLEN-16){if_id_instr[15]}}, if_id_instr[15:0]};
  assign ctrl = decode_ctrl(if_id_instr[31:0]);

  decode_stage_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_reg_write),
    .waddr  (wb_write_reg),
    .wdata  (wb_write_data)
  );

  // A load in EX whose destination feeds this instruction cannot be forwarded in time.
  assign hazard = id_ex_valid && id_ex_ctrl.mem_read && (id_ex_rt != '0) &&
                  ((id_ex_rt == rs) || (uses_rt(if_id_instr[31:26]) && (id_ex_rt == rt)));

  // A taken branch squashes the instruction anyway, so it overrides the stall.
  assign id_stall = hazard && !ex_mem_pc_src;
  assign bubble   = id_stall || ex_mem_pc_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_valid  <= 1'b0;
      id_ex_ctrl   <= CTRL_NONE;
      id_ex_npc    <= '0;
      id_ex_rdata1 <= '0;
      id_ex_rdata2 <= '0;
      id_ex_imm    <= '0;
      id_ex_rs     <= '0;
      id_ex_rt     <= '0;
      id_ex_rd     <= '0;
    end else if (bubble) begin
      id_ex_valid  <= 1'b0;
      id_ex_ctrl   <= CTRL_NONE;
      id_ex_npc    <= '0;
      id_ex_rdata1 <= '0;
      id_ex_rdata2 <= '0;
      id_ex_imm    <= '0;
      id_ex_rs     <= '0;
      id_ex_rt     <= '0;
      id_ex_rd     <= '0;
    end else begin
      id_ex_valid  <= 1'b1;
      id_ex_ctrl   <= ctrl;
      id_ex_npc    <= if_id_npc;
      id_ex_rdata1 <= rdata1;
      id_ex_rdata2 <= rdata2;
      id_ex_imm    <= imm;
      id_ex_rs     <= rs;
      id_ex_rt     <= rt;
      id_ex_rd     <= rd;
    end
  end

  assign id_ex_reg_dst    = id_ex_ctrl.reg_dst;
  assign id_ex_alu_src    = id_ex_ctrl.alu_src;
  assign id_ex_alu_op     = id_ex_ctrl.alu_op;
  assign id_ex_mem_read   = id_ex_ctrl.mem_read;
  assign id_ex_mem_write  = id_ex_ctrl.mem_write;
  assign id_ex_reg_write  = id_ex_ctrl.reg_write;
  assign id_ex_mem_to_reg = id_ex_ctrl.mem_to_reg;
  assign id_ex_branch     = id_ex_ctrl.branch;

endmodule
